// File: rtl/ptp_pdelay_initiator.sv
// ptp_pdelay_initiator
// Peer-delay initiator sequencer for one 802.1AS port. Paces Pdelay_Req
// transmission, owns the request sequenceId, checks the response /
// follow-up ordering and sequenceIds, times out each response stage,
// kicks the path-delay calculator and tracks lost responses.
module ptp_pdelay_initiator #(
  parameter int unsigned INTERVAL_CYCLES     = 250000000,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 2500000,
  parameter int unsigned LOST_LIMIT          = 3,
  parameter int unsigned CNT_WIDTH           = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_pdelay_event_start,
  input  logic        i_pdelay_event_req_send_end,
  input  logic        i_pdelay_event_resp_rec_end,
  input  logic [15:0] i_pdelay_resp_sequenceid,
  input  logic        i_pdelay_event_respfw_rec_end,
  input  logic [15:0] i_pdelay_respfw_sequenceid,
  input  logic        i_pdelay_event_end,
  output logic        o_pdelay_req_send,
  output logic [15:0] o_pdelay_req_sequenceid,
  output logic        o_pdelay_calc_start,
  output logic [7:0]  o_lost_resp_cnt,
  output logic        o_as_capable_lost,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND        = 3'd1,
    WAIT_TX     = 3'd2,
    WAIT_RESP   = 3'd3,
    WAIT_RESPFW = 3'd4,
    CALC        = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] INTERVAL_LAST = CNT_WIDTH'(INTERVAL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST  = CNT_WIDTH'(RESP_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
  localparam logic [7:0]           LOST_LIMIT_W  = 8'(LOST_LIMIT);

  state_t               state;
  logic [CNT_WIDTH-1:0] interval_cnt;
  logic [CNT_WIDTH-1:0] timeout_cnt;
  logic [15:0]          seq_id;
  logic [7:0]           lost_cnt;

  logic interval_hit;
  logic timeout_hit;
  logic trigger;
  logic commit;
  logic resp_match;
  logic respfw_match;
  logic progress;
  logic in_wait;
  logic timeout_abort;

  assign o_state                 = state;
  assign o_pdelay_req_sequenceid = seq_id;
  assign o_lost_resp_cnt         = lost_cnt;

  // Decode triggers, matching events and the timeout condition for this cycle
  always_comb begin
    interval_hit = (interval_cnt == INTERVAL_LAST);
    timeout_hit  = (timeout_cnt == TIMEOUT_LAST);
    trigger      = interval_hit || i_pdelay_event_start;
    commit       = (state == IDLE) && i_enable && trigger;
    resp_match   = i_pdelay_event_resp_rec_end &&
                   (i_pdelay_resp_sequenceid == seq_id);
    respfw_match = i_pdelay_event_respfw_rec_end &&
                   (i_pdelay_respfw_sequenceid == seq_id);
    progress     = 1'b0;
    in_wait      = 1'b0;
    case (state)
      WAIT_TX: begin
        progress = i_pdelay_event_req_send_end;
        in_wait  = 1'b1;
      end
      WAIT_RESP: begin
        progress = resp_match;
        in_wait  = 1'b1;
      end
      WAIT_RESPFW: begin
        progress = respfw_match;
        in_wait  = 1'b1;
      end
      default: begin
        progress = 1'b0;
        in_wait  = 1'b0;
      end
    endcase
    // an expected event in the expiry cycle takes precedence over the timeout
    timeout_abort = in_wait && timeout_hit && !progress;
  end

  // Interval counter: wraps every INTERVAL_CYCLES and restarts whenever a
  // request is committed, so periodic requests stay exactly one period apart
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      interval_cnt <= '0;
    end else if (!i_enable || commit || interval_hit) begin
      interval_cnt <= '0;
    end else begin
      interval_cnt <= interval_cnt + CNT_ONE;
    end
  end

  // Measurement sequencer with its timeout counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state               <= IDLE;
      timeout_cnt         <= '0;
      seq_id              <= 16'h0000;
      lost_cnt            <= 8'h00;
      o_pdelay_req_send   <= 1'b0;
      o_pdelay_calc_start <= 1'b0;
      o_as_capable_lost   <= 1'b0;
    end else begin
      o_pdelay_req_send   <= 1'b0;
      o_pdelay_calc_start <= 1'b0;
      o_as_capable_lost   <= (lost_cnt > LOST_LIMIT_W);

      if (!i_enable) begin
        state       <= IDLE;
        timeout_cnt <= '0;
      end else if (timeout_abort) begin
        state       <= IDLE;
        timeout_cnt <= '0;
        seq_id      <= seq_id + 16'd1;
        if (lost_cnt != 8'hFF) begin
          lost_cnt <= lost_cnt + 8'd1;
        end
      end else begin
        case (state)
          IDLE: begin
            timeout_cnt <= '0;
            if (trigger) begin
              state <= SEND;
            end
          end
          SEND: begin
            o_pdelay_req_send <= 1'b1;
            timeout_cnt       <= '0;
            state             <= WAIT_TX;
          end
          WAIT_TX: begin
            if (i_pdelay_event_req_send_end) begin
              state       <= WAIT_RESP;
              timeout_cnt <= '0;
            end else begin
              timeout_cnt <= timeout_cnt + CNT_ONE;
            end
          end
          WAIT_RESP: begin
            if (resp_match) begin
              state       <= WAIT_RESPFW;
              timeout_cnt <= '0;
            end else begin
              timeout_cnt <= timeout_cnt + CNT_ONE;
            end
          end
          WAIT_RESPFW: begin
            if (respfw_match) begin
              state               <= CALC;
              o_pdelay_calc_start <= 1'b1;
              timeout_cnt         <= '0;
            end else begin
              timeout_cnt <= timeout_cnt + CNT_ONE;
            end
          end
          CALC: begin
            timeout_cnt <= '0;
            if (i_pdelay_event_end) begin
              state    <= IDLE;
              lost_cnt <= 8'h00;
              seq_id   <= seq_id + 16'd1;
            end
          end
          default: begin
            state       <= IDLE;
            timeout_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ptp_pdelay_initiator.sv
// tb_ptp_pdelay_initiator
// Directed bench for the peer-delay initiator with a short interval (1000)
// and response timeout (100) so every scenario fits in a few thousand cycles.
module tb_ptp_pdelay_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        ev_start = 1'b0;
  logic        ev_req_end = 1'b0;
  logic        ev_resp = 1'b0;
  logic [15:0] resp_id = 16'h0000;
  logic        ev_respfw = 1'b0;
  logic [15:0] respfw_id = 16'h0000;
  logic        ev_end = 1'b0;

  logic        req_send;
  logic [15:0] req_seq;
  logic        calc_start;
  logic [7:0]  lost_cnt;
  logic        as_cap_lost;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p1 = 0;
  bit seen = 1'b0;

  ptp_pdelay_initiator #(
    .INTERVAL_CYCLES     (1000),
    .RESP_TIMEOUT_CYCLES (100),
    .LOST_LIMIT          (3),
    .CNT_WIDTH           (32)
  ) dut (
    .i_clk                         (clk),
    .i_rst                         (rst_n),
    .i_enable                      (enable),
    .i_pdelay_event_start          (ev_start),
    .i_pdelay_event_req_send_end   (ev_req_end),
    .i_pdelay_event_resp_rec_end   (ev_resp),
    .i_pdelay_resp_sequenceid      (resp_id),
    .i_pdelay_event_respfw_rec_end (ev_respfw),
    .i_pdelay_respfw_sequenceid    (respfw_id),
    .i_pdelay_event_end            (ev_end),
    .o_pdelay_req_send             (req_send),
    .o_pdelay_req_sequenceid       (req_seq),
    .o_pdelay_calc_start           (calc_start),
    .o_lost_resp_cnt               (lost_cnt),
    .o_as_capable_lost             (as_cap_lost),
    .o_state                       (state)
  );

  // Free-running 100 MHz-style bench clock
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock edge; outputs are read 1 time unit after it and pulses drop
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ev_start   = 1'b0;
    ev_req_end = 1'b0;
    ev_resp    = 1'b0;
    ev_respfw  = 1'b0;
    ev_end     = 1'b0;
  endtask

  // Start a measurement from IDLE and check the request pulse and its id
  task automatic request(input string tag, input logic [15:0] exp_seq);
    ev_start = 1'b1;
    step();
    check({tag, "_send_state"}, 32'(state), 32'd1);
    check({tag, "_no_early_pulse"}, 32'(req_send), 32'd0);
    step();
    check({tag, "_req_pulse"}, 32'(req_send), 32'd1);
    check({tag, "_req_seq"}, 32'(req_seq), 32'(exp_seq));
    check({tag, "_wait_tx"}, 32'(state), 32'd2);
  endtask

  // The wait state lasts exactly 100 cycles from its entry edge
  task automatic run_to_timeout(input string tag, input logic [2:0] wait_state);
    repeat (99) step();
    check({tag, "_still_waiting"}, 32'(state), 32'(wait_state));
    step();
    check({tag, "_timed_out"}, 32'(state), 32'd0);
  endtask

  task automatic wait_req_pulse(input int limit);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      if (req_send) seen = 1'b1;
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_seq", 32'(req_seq), 32'd0);
    check("rst_lost", 32'(lost_cnt), 32'd0);
    check("rst_req_send", 32'(req_send), 32'd0);
    check("rst_calc", 32'(calc_start), 32'd0);
    check("rst_ascap", 32'(as_cap_lost), 32'd0);
    rst_n = 1'b1;

    // Full measurement with sequenceId 0
    enable = 1'b1;
    request("m0", 16'h0000);
    ev_req_end = 1'b1; step();
    check("m0_wait_resp", 32'(state), 32'd3);
    check("m0_pulse_single", 32'(req_send), 32'd0);
    resp_id = 16'h0000; ev_resp = 1'b1; step();
    check("m0_wait_respfw", 32'(state), 32'd4);
    respfw_id = 16'h0000; ev_respfw = 1'b1; step();
    check("m0_calc_state", 32'(state), 32'd5);
    check("m0_calc_pulse", 32'(calc_start), 32'd1);
    step();
    check("m0_calc_single", 32'(calc_start), 32'd0);
    check("m0_calc_hold", 32'(state), 32'd5);
    ev_end = 1'b1; step();
    check("m0_idle", 32'(state), 32'd0);
    check("m0_seq_next", 32'(req_seq), 32'd1);
    check("m0_lost", 32'(lost_cnt), 32'd0);

    // Start while busy is dropped; stray and mismatched events are ignored
    request("m1", 16'h0001);
    ev_start = 1'b1; step();
    check("m1_busy_start_state", 32'(state), 32'd2);
    check("m1_busy_start_nopulse", 32'(req_send), 32'd0);
    resp_id = 16'h0001; ev_resp = 1'b1; step();
    check("m1_early_resp_ignored", 32'(state), 32'd2);
    check("m1_still_nopulse", 32'(req_send), 32'd0);
    ev_req_end = 1'b1; step();
    resp_id = 16'h0001; ev_resp = 1'b1; step();
    check("m1_wait_respfw", 32'(state), 32'd4);
    respfw_id = 16'h0007; ev_respfw = 1'b1; step();
    check("m1_bad_fw_ignored", 32'(state), 32'd4);
    check("m1_bad_fw_nocalc", 32'(calc_start), 32'd0);
    respfw_id = 16'h0001; ev_respfw = 1'b1; step();
    check("m1_calc_pulse", 32'(calc_start), 32'd1);
    ev_end = 1'b1; step();
    check("m1_seq_next", 32'(req_seq), 32'd2);

    // Mismatched response id, then enable drop in WAIT_RESPFW
    request("m2", 16'h0002);
    ev_req_end = 1'b1; step();
    resp_id = 16'h0005; ev_resp = 1'b1; step();
    check("m2_bad_resp_ignored", 32'(state), 32'd3);
    resp_id = 16'h0002; ev_resp = 1'b1; step();
    check("m2_good_resp", 32'(state), 32'd4);
    enable = 1'b0; step();
    check("m2_disable_idle", 32'(state), 32'd0);
    check("m2_disable_lost", 32'(lost_cnt), 32'd0);
    check("m2_disable_seq", 32'(req_seq), 32'd2);
    enable = 1'b1;

    // Timeout in WAIT_RESP
    request("t1", 16'h0002);
    ev_req_end = 1'b1; step();
    run_to_timeout("t1", 3'd3);
    check("t1_lost", 32'(lost_cnt), 32'd1);
    check("t1_seq", 32'(req_seq), 32'd3);

    // Timeout in WAIT_TX
    request("t2", 16'h0003);
    run_to_timeout("t2", 3'd2);
    check("t2_lost", 32'(lost_cnt), 32'd2);
    check("t2_seq", 32'(req_seq), 32'd4);

    // Timeout in WAIT_RESPFW
    request("t3", 16'h0004);
    ev_req_end = 1'b1; step();
    resp_id = 16'h0004; ev_resp = 1'b1; step();
    run_to_timeout("t3", 3'd4);
    check("t3_lost", 32'(lost_cnt), 32'd3);
    step();
    check("t3_ascap_at_limit", 32'(as_cap_lost), 32'd0);

    // Fourth timeout pushes the count past the limit; flag lags one cycle
    request("t4", 16'h0005);
    ev_req_end = 1'b1; step();
    run_to_timeout("t4", 3'd3);
    check("t4_lost", 32'(lost_cnt), 32'd4);
    check("t4_ascap_lag", 32'(as_cap_lost), 32'd0);
    step();
    check("t4_ascap_set", 32'(as_cap_lost), 32'd1);

    // Matching response in the expiry cycle wins, then success clears both
    request("s1", 16'h0006);
    ev_req_end = 1'b1; step();
    repeat (99) step();
    check("s1_at_expiry", 32'(state), 32'd3);
    resp_id = 16'h0006; ev_resp = 1'b1; step();
    check("s1_event_wins", 32'(state), 32'd4);
    check("s1_no_lost_inc", 32'(lost_cnt), 32'd4);
    respfw_id = 16'h0006; ev_respfw = 1'b1; step();
    check("s1_calc", 32'(calc_start), 32'd1);
    ev_end = 1'b1; step();
    check("s1_lost_clear", 32'(lost_cnt), 32'd0);
    check("s1_seq", 32'(req_seq), 32'd7);
    step();
    check("s1_ascap_clear", 32'(as_cap_lost), 32'd0);

    // Periodic requests with no start pulses
    enable = 1'b0; step();
    enable = 1'b1;
    wait_req_pulse(1100);
    check("int_first_seen", 32'(seen), 32'd1);
    check("int_first_seq", 32'(req_seq), 32'd7);
    p1 = cyc;
    ev_req_end = 1'b1; step();
    resp_id = 16'h0007; ev_resp = 1'b1; step();
    respfw_id = 16'h0007; ev_respfw = 1'b1; step();
    ev_end = 1'b1; step();
    check("int_done_seq", 32'(req_seq), 32'd8);
    wait_req_pulse(1100);
    check("int_second_seen", 32'(seen), 32'd1);
    check("int_period", 32'(cyc - p1), 32'd1000);
    check("int_second_seq", 32'(req_seq), 32'd8);

    // sequenceId wrap from 0xFFFF to 0x0000
    enable = 1'b0; step();
    check("wrap_idle", 32'(state), 32'd0);
    force dut.seq_id = 16'hFFFF;
    step();
    release dut.seq_id;
    step();
    enable = 1'b1;
    request("w1", 16'hFFFF);
    ev_req_end = 1'b1; step();
    resp_id = 16'hFFFF; ev_resp = 1'b1; step();
    respfw_id = 16'hFFFF; ev_respfw = 1'b1; step();
    ev_end = 1'b1; step();
    check("w1_wrapped", 32'(req_seq), 32'd0);
    request("w2", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
